fifo_ms_read_arb: RTL and testbench
===================================

# fifo_ms_read_arb

Read-side scheduler for the multi-stream FIFO: observes the per-flux `empty` flags and pops one entry per cycle through the one-hot `read` vector, granting fluxes round-robin with bounded bursts. Each popped word is registered into a valid/ready output stage together with its flux tag. The block sits between the FIFO's read port and a single downstream consumer, so one sink can drain all fluxes fairly.

## Interface
- `DATA_WIDTH`, 8, payload width per entry
- `FLUX`, 2, number of streams; must be ≥ 2
- `MAX_BURST`, 4, maximum consecutive pops granted to one flux before rotation; must be ≥ 1
- `TAG_WIDTH`, `$clog2(FLUX)`, derived; do not override
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `empty`  in  FLUX  per-flux empty flags from the FIFO
- `fifo_dout`  in  TAG_WIDTH+DATA_WIDTH  FIFO read data, {tag, data}, valid combinationally for the flux selected by `read`
- `flux_en`  in  FLUX  per-flux enable mask; a disabled flux is never granted
- `read`  out  FLUX  one-hot pop strobe to the FIFO; all-zero when idle
- `out_data`  out  DATA_WIDTH  registered payload
- `out_tag`  out  TAG_WIDTH  flux index of `out_data`
- `out_valid`  out  1  output holds a word
- `out_ready`  in  1  consumer accepts the word
- `grant_cnt`  out  FLUX×16  per-flux pop counters (see Configuration)

## Operation
- `can_load = !out_valid || out_ready`. `read` is all-zero whenever `can_load` is 0.
- FSM states: `ARB`, `BURST`. Registers: `cur` (granted flux), `last` (last granted flux), `burst_cnt` (1..MAX_BURST).
- Candidates: `cand = ~empty & flux_en`.
- Continuation is taken when state is `BURST`, `cand[cur]` is set, and `burst_cnt < MAX_BURST`. The grant is then `cur`, and `burst_cnt` increments.
- Otherwise, if `cand` is non-zero, the grant is the first set bit of `cand` searching from `last+1` with wrap modulo FLUX. This happens in the same cycle, with no bubble. Then `cur <= g`, `burst_cnt <= 1`, state becomes `BURST`, or `ARB` if MAX_BURST == 1.
- If `cand` is zero, there is no grant and the state returns to `ARB`.
- On a grant g with `can_load`:
  - `read[g] = 1`.
  - At the clock edge: `out_data <= fifo_dout[DATA_WIDTH-1:0]`, `out_tag <= g`, `out_valid <= 1`, `last <= g`.
- Without a grant: `out_valid` clears when `out_ready` is high.
- If `fifo_dout` tag bits ≠ g during a pop, a simulation assertion fails. `out_tag` always comes from g.
- Disabling `flux_en[cur]` mid-burst ends the burst in that cycle.

## Timing
- Reset values:
  - `read` = 0, `out_valid` = 0, `out_data` = 0, `out_tag` = 0.
  - `grant_cnt` = 0, state `ARB`, `burst_cnt` = 0, `cur` = 0.
  - `last` = FLUX-1, so the first search starts at flux 0.
- `read` is combinational (Mealy) from `empty`, `flux_en`, `out_ready` and state. The FIFO pops on the same edge that loads the output register.
- Latency: pop to `out_valid` is 1 cycle.
- Throughput: 1 word/cycle while `out_ready` is held high.
- Backpressure: with `out_valid && !out_ready`, the output and all state hold, and no pop occurs.
- Reset asserted mid-operation clears outputs immediately. A word held in the output register is discarded.
- The reset deassertion edge is synchronised externally.

## Configuration
- `FIFO_MS_ARB_STATS_EN` defined:
  - `grant_cnt[f]` increments on every pop of flux f.
  - Counters saturate at 16'hFFFF.
  - Counters clear only on reset.
- `FIFO_MS_ARB_STATS_EN` undefined: `grant_cnt` is tied to 0 and no counter flops are generated.

## Structure
- Package `fifo_ms_arb_pkg`:
  - state enum `arb_state_t {ARB, BURST}`
  - counter width constant `GCNT_W = 16`
- Sub-module `rr_pick`: combinational, parameterised by FLUX.
  - Inputs: request vector, start index.
  - Outputs: one-hot grant, binary index, valid.
- The FSM, output register and counters live in the top module.

## Test plan
- FLUX=2, MAX_BURST=4: fill flux0 with 6 words and flux1 with 6 words, `out_ready` = 1 → tag order 0,0,0,0,1,1,1,1,0,0,1,1, with no idle cycle.
- Only flux1 non-empty holding 3 words, `flux_en` = 2'b11 → `read` = 2'b10 on three consecutive cycles, then 0; `out_valid` is high for 3 cycles.
- Stream running, drop `out_ready` for 5 cycles → `read` = 0 and `out_data`/`out_tag` are stable throughout; the stream resumes with no word lost or duplicated.
- Both fluxes non-empty with `flux_en` = 2'b01; set `flux_en[0]` = 0 mid-burst → no grant to flux1 ever; grants to flux0 stop in the cycle the enable falls.
- Mid-stream `rst` pulse low → `out_valid` and `read` drop to 0 immediately; after release, the first grant goes to flux 0.
- With `FIFO_MS_ARB_STATS_EN`: 10 pops of flux0 and 3 pops of flux1 → `grant_cnt` = {16'd3, 16'd10}. Without the macro → `grant_cnt` = 0.

Source files
------------

// File: rtl/fifo_ms_read_arb_pkg.sv
// Shared types and constants for the multi-stream FIFO read arbiter.
package fifo_ms_arb_pkg;

    // Arbiter FSM: ARB searches for a new flux, BURST continues the current one.
    typedef enum logic [0:0] {
        ARB   = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    // Width of each per-flux pop counter.
    localparam int GCNT_W = 16;

endpackage

// File: rtl/fifo_ms_read_arb_if.sv
// FIFO read port plus valid/ready output stage of the multi-stream read arbiter.
// master: the arbiter; slave: the FIFO and downstream consumer side.
interface fifo_ms_read_arb_if #(
    parameter int DATA_WIDTH = 8,
    parameter int FLUX       = 2
);
    localparam int TAG_WIDTH = $clog2(FLUX);

    logic [FLUX-1:0]                 empty;
    logic [TAG_WIDTH+DATA_WIDTH-1:0] fifo_dout;
    logic [FLUX-1:0]                 read;
    logic [DATA_WIDTH-1:0]           out_data;
    logic [TAG_WIDTH-1:0]            out_tag;
    logic                            out_valid;
    logic                            out_ready;

    modport master (
        input  empty,
        input  fifo_dout,
        input  out_ready,
        output read,
        output out_data,
        output out_tag,
        output out_valid
    );

    modport slave (
        output empty,
        output fifo_dout,
        output out_ready,
        input  read,
        input  out_data,
        input  out_tag,
        input  out_valid
    );
endinterface

// File: rtl/fifo_ms_read_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or after `start`,
// wrapping modulo FLUX.
module rr_pick #(
    parameter int FLUX  = 2,
    parameter int IDX_W = $clog2(FLUX)
) (
    input  logic [FLUX-1:0]  req,
    input  logic [IDX_W-1:0] start,
    output logic [FLUX-1:0]  gnt,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    // Scan FLUX positions starting at `start`, keep the first hit.
    always_comb begin
        int j;
        logic [IDX_W-1:0] jj;
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        j     = 0;
        jj    = '0;
        for (int i = 0; i < FLUX; i++) begin
            j = int'(start) + i;
            if (j >= FLUX) begin
                j = j - FLUX;
            end
            jj = IDX_W'(j);
            if (!valid && req[jj]) begin
                valid   = 1'b1;
                gnt[jj] = 1'b1;
                idx     = jj;
            end
        end
    end

endmodule

// File: rtl/fifo_ms_read_arb.sv
// Read-side scheduler for the multi-stream FIFO: round-robin across fluxes with
// bounded bursts, popping one word per cycle into a registered valid/ready stage.
// Optional build macro FIFO_MS_ARB_STATS_EN enables saturating per-flux pop counters;
// without it grant_cnt is tied to zero.
module fifo_ms_read_arb
    import fifo_ms_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FLUX       = 2,
    parameter int MAX_BURST  = 4,
    parameter int TAG_WIDTH  = $clog2(FLUX)
) (
    input  logic                     clk,
    input  logic                     rst,
    fifo_ms_read_arb_if.master       bus,
    input  logic [FLUX-1:0]          flux_en,
    output logic [FLUX*GCNT_W-1:0]   grant_cnt
);

    localparam int BCW = $clog2(MAX_BURST + 1);

    arb_state_t            state_q;
    logic [TAG_WIDTH-1:0]  cur_q;
    logic [TAG_WIDTH-1:0]  last_q;
    logic [BCW-1:0]        burst_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic [TAG_WIDTH-1:0]  out_tag_q;
    logic                  out_valid_q;

    logic [FLUX-1:0]       cand;
    logic [FLUX-1:0]       pick_gnt;
    logic [TAG_WIDTH-1:0]  pick_idx;
    logic                  pick_valid;
    logic [TAG_WIDTH-1:0]  start_idx;
    logic [TAG_WIDTH-1:0]  g;
    logic [FLUX-1:0]       read_vec;
    logic                  can_load;
    logic                  cont;
    logic                  grant;
    logic                  pop;

    assign cand     = ~bus.empty & flux_en;
    assign can_load = !out_valid_q || bus.out_ready;

    // Search origin is the flux after the last one served, wrapping.
    always_comb begin
        if (last_q == TAG_WIDTH'(FLUX - 1)) begin
            start_idx = '0;
        end else begin
            start_idx = last_q + TAG_WIDTH'(1);
        end
    end

    rr_pick #(
        .FLUX  (FLUX),
        .IDX_W (TAG_WIDTH)
    ) u_rr_pick (
        .req   (cand),
        .start (start_idx),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    assign cont  = (state_q == BURST) && cand[cur_q] && (burst_q < BCW'(MAX_BURST));
    assign g     = cont ? cur_q : pick_idx;
    assign grant = cont || pick_valid;
    // Reset gates the Mealy strobe so the FIFO never pops while held in reset.
    assign pop   = grant && can_load && rst;

    // One-hot pop strobe to the FIFO.
    always_comb begin
        read_vec = '0;
        if (pop) begin
            read_vec = cont ? (FLUX'(1) << cur_q) : pick_gnt;
        end
    end

    assign bus.read      = read_vec;
    assign bus.out_data  = out_data_q;
    assign bus.out_tag   = out_tag_q;
    assign bus.out_valid = out_valid_q;

    // Arbiter state and output register; everything holds under backpressure.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ARB;
            cur_q       <= '0;
            last_q      <= TAG_WIDTH'(FLUX - 1);
            burst_q     <= '0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
            out_valid_q <= 1'b0;
        end else if (can_load) begin
            if (grant) begin
                out_data_q  <= bus.fifo_dout[DATA_WIDTH-1:0];
                out_tag_q   <= g;
                out_valid_q <= 1'b1;
                last_q      <= g;
                if (cont) begin
                    burst_q <= burst_q + BCW'(1);
                end else begin
                    cur_q   <= g;
                    burst_q <= BCW'(1);
                    state_q <= (MAX_BURST == 1) ? ARB : BURST;
                end
            end else begin
                out_valid_q <= 1'b0;
                state_q     <= ARB;
            end
        end
    end

    // The FIFO must present the word of the flux being popped.
    tag_match: assert property (@(posedge clk) disable iff (!rst)
        pop |-> (bus.fifo_dout[TAG_WIDTH+DATA_WIDTH-1:DATA_WIDTH] == g));

`ifdef FIFO_MS_ARB_STATS_EN
    for (genvar f = 0; f < FLUX; f++) begin : g_cnt
        logic [GCNT_W-1:0] cnt_q;

        // Saturating pop counter for flux f; only reset clears it.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                cnt_q <= '0;
            end else if (read_vec[f] && (cnt_q != '1)) begin
                cnt_q <= cnt_q + GCNT_W'(1);
            end
        end

        assign grant_cnt[f*GCNT_W +: GCNT_W] = cnt_q;
    end
`else
    assign grant_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_ms_read_arb.sv
// Self-checking bench for fifo_ms_read_arb: a behavioural FIFO feeds the DUT and a
// queue-based round-robin/burst model predicts each cycle's pop and output word.
module tb_fifo_ms_read_arb;

    localparam int DW        = 8;
    localparam int FLUX      = 2;
    localparam int MAX_BURST = 4;
    localparam int TW        = 1;
    localparam int DEPTH     = 1024;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [FLUX-1:0]   flux_en = '0;
    logic [FLUX*16-1:0] grant_cnt;

    fifo_ms_read_arb_if #(.DATA_WIDTH(DW), .FLUX(FLUX)) bus ();

    fifo_ms_read_arb #(
        .DATA_WIDTH (DW),
        .FLUX       (FLUX),
        .MAX_BURST  (MAX_BURST)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .flux_en   (flux_en),
        .grant_cnt (grant_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Behavioural multi-stream FIFO.
    logic [DW-1:0] mem [FLUX][DEPTH];
    int wr_ptr [FLUX] = '{default: 0};
    int rd_ptr [FLUX] = '{default: 0};

    always_comb begin
        bus.empty     = '0;
        bus.fifo_dout = {1'b0, mem[0][rd_ptr[0] % DEPTH]};
        for (int f = 0; f < FLUX; f++) begin
            bus.empty[f] = (wr_ptr[f] == rd_ptr[f]);
            if (bus.read[f]) bus.fifo_dout = {TW'(f), mem[f][rd_ptr[f] % DEPTH]};
        end
    end

    always @(posedge clk) begin
        for (int f = 0; f < FLUX; f++) begin
            if (bus.read[f]) rd_ptr[f] <= rd_ptr[f] + 1;
        end
    end

    // Reference model state.
    logic [DW-1:0] m_q [FLUX][$];
    int m_last, m_cur, m_blen, m_g;
    int m_cnt [FLUX];
    bit m_burst, m_valid, m_load, m_cont;
    logic [DW-1:0]   exp_data;
    logic [TW-1:0]   exp_tag;
    logic [FLUX-1:0] exp_read;

    task automatic push(input int f, input logic [DW-1:0] d);
        mem[f][wr_ptr[f] % DEPTH] = d;
        wr_ptr[f]++;
        m_q[f].push_back(d);
    endtask

    task automatic model_reset();
        m_last = FLUX - 1; m_cur = 0; m_blen = 0; m_burst = 0; m_valid = 0;
        exp_data = '0; exp_tag = '0;
        for (int f = 0; f < FLUX; f++) m_cnt[f] = 0;
    endtask

    // Decide this cycle's grant from queue occupancy, enables and burst history.
    task automatic predict();
        bit has [FLUX];
        m_g = -1; m_cont = 0;
        m_load = !m_valid || bus.out_ready;
        for (int f = 0; f < FLUX; f++) has[f] = (m_q[f].size() > 0) && flux_en[f];
        if (rst && m_load) begin
            if (m_burst && has[m_cur] && m_blen < MAX_BURST) begin
                m_g = m_cur; m_cont = 1;
            end else begin
                for (int k = 1; k <= FLUX; k++) begin
                    int ff;
                    ff = (m_last + k) % FLUX;
                    if (m_g < 0 && has[ff]) m_g = ff;
                end
            end
        end
        for (int f = 0; f < FLUX; f++) exp_read[f] = (m_g == f);
    endtask

    task automatic commit();
        if (rst && m_load) begin
            if (m_g >= 0) begin
                exp_data = m_q[m_g].pop_front();
                exp_tag  = TW'(m_g);
                m_valid  = 1;
                m_last   = m_g;
                if (m_cnt[m_g] < 65535) m_cnt[m_g]++;
                if (m_cont) m_blen++;
                else begin m_cur = m_g; m_blen = 1; m_burst = (MAX_BURST > 1); end
            end else begin
                m_valid = 0; m_burst = 0;
            end
        end
    endtask

    task automatic pre_edge(input bit rdy, input logic [FLUX-1:0] en);
        @(negedge clk);
        bus.out_ready = rdy;
        flux_en = en;
        #1;
        predict();
    endtask

    task automatic post_edge();
        @(posedge clk);
        #1;
        commit();
    endtask

    task automatic apply_reset();
        #2;
        rst = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        predict();
    endtask

    task automatic test_reset();
        bus.out_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        checks++; if (bus.read !== 2'b00) begin errors++; $display("FAIL reset_read: got %b expected 00", bus.read); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.out_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", bus.out_data); end
        checks++; if (bus.out_tag !== 1'b0) begin errors++; $display("FAIL reset_tag: got %b expected 0", bus.out_tag); end
        checks++; if (grant_cnt !== '0) begin errors++; $display("FAIL reset_gcnt: got %h expected 0", grant_cnt); end
        rst = 1'b1;
        #1;
        predict();
        post_edge();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_idle_valid: got %b expected 0", bus.out_valid); end
    endtask

    task automatic test_burst_order();
        int exp_order [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 1, 1};
        int tags [$];
        for (int i = 0; i < 6; i++) begin
            push(0, 8'($urandom)); push(1, 8'($urandom));
        end
        for (int c = 0; c < 14; c++) begin
            pre_edge(1'b1, 2'b11);
            checks++; if (bus.read !== exp_read) begin errors++; $display("FAIL burst_read c%0d: got %b expected %b", c, bus.read, exp_read); end
            post_edge();
            checks++; if ({bus.out_valid, bus.out_tag, bus.out_data} !== {m_valid, exp_tag, exp_data})
                begin errors++; $display("FAIL burst_out c%0d: got %b/%b/%h expected %b/%b/%h", c, bus.out_valid, bus.out_tag, bus.out_data, m_valid, exp_tag, exp_data); end
            if (c < 12) begin
                checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL burst_no_idle c%0d: got %b expected 1", c, bus.out_valid); end
            end
            if (bus.out_valid === 1'b1) tags.push_back(int'(bus.out_tag));
        end
        checks++;
        if (tags.size() != 12) begin
            errors++; $display("FAIL burst_count: got %0d expected 12", tags.size());
        end else begin
            for (int i = 0; i < 12; i++) begin
                if (tags[i] != exp_order[i]) begin
                    errors++; $display("FAIL burst_order[%0d]: got %0d expected %0d", i, tags[i], exp_order[i]);
                end
            end
        end
    endtask

    task automatic test_single_flux();
        logic [1:0] exp_r [5] = '{2'b10, 2'b10, 2'b10, 2'b00, 2'b00};
        int nvalid = 0;
        for (int i = 0; i < 3; i++) push(1, 8'($urandom));
        for (int c = 0; c < 5; c++) begin
            pre_edge(1'b1, 2'b11);
            checks++; if (bus.read !== exp_r[c]) begin errors++; $display("FAIL single_read c%0d: got %b expected %b", c, bus.read, exp_r[c]); end
            checks++; if (bus.read !== exp_read) begin errors++; $display("FAIL single_model c%0d: got %b expected %b", c, bus.read, exp_read); end
            post_edge();
            checks++; if ({bus.out_valid, bus.out_tag, bus.out_data} !== {m_valid, exp_tag, exp_data})
                begin errors++; $display("FAIL single_out c%0d: got %b/%b/%h expected %b/%b/%h", c, bus.out_valid, bus.out_tag, bus.out_data, m_valid, exp_tag, exp_data); end
            if (bus.out_valid === 1'b1) nvalid++;
        end
        checks++; if (nvalid != 3) begin errors++; $display("FAIL single_valid_cycles: got %0d expected 3", nvalid); end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] held_data;
        logic [TW-1:0] held_tag;
        held_data = '0; held_tag = '0;
        for (int i = 0; i < 8; i++) begin
            push(0, 8'($urandom)); push(1, 8'($urandom));
        end
        for (int c = 0; c < 32; c++) begin
            pre_edge(!(c >= 3 && c < 8), 2'b11);
            checks++; if (bus.read !== exp_read) begin errors++; $display("FAIL bp_read c%0d: got %b expected %b", c, bus.read, exp_read); end
            if (c >= 3 && c < 8) begin
                checks++; if (bus.read !== 2'b00) begin errors++; $display("FAIL bp_stall_read c%0d: got %b expected 00", c, bus.read); end
            end
            post_edge();
            checks++; if ({bus.out_valid, bus.out_tag, bus.out_data} !== {m_valid, exp_tag, exp_data})
                begin errors++; $display("FAIL bp_out c%0d: got %b/%b/%h expected %b/%b/%h", c, bus.out_valid, bus.out_tag, bus.out_data, m_valid, exp_tag, exp_data); end
            if (c == 2) begin held_data = exp_data; held_tag = exp_tag; end
            if (c >= 3 && c < 8) begin
                checks++; if ({bus.out_tag, bus.out_data} !== {held_tag, held_data})
                    begin errors++; $display("FAIL bp_stable c%0d: got %b/%h expected %b/%h", c, bus.out_tag, bus.out_data, held_tag, held_data); end
            end
        end
        checks++; if (wr_ptr[0] != rd_ptr[0] || wr_ptr[1] != rd_ptr[1] || m_q[0].size() != 0 || m_q[1].size() != 0)
            begin errors++; $display("FAIL bp_drain: got rd %0d/%0d expected %0d/%0d", rd_ptr[0], rd_ptr[1], wr_ptr[0], wr_ptr[1]); end
    endtask

    task automatic test_flux_en();
        for (int i = 0; i < 6; i++) begin
            push(0, 8'($urandom)); push(1, 8'($urandom));
        end
        for (int c = 0; c < 24; c++) begin
            pre_edge(1'b1, (c < 2) ? 2'b01 : (c == 2) ? 2'b00 : 2'b11);
            checks++; if (bus.read !== exp_read) begin errors++; $display("FAIL en_read c%0d: got %b expected %b", c, bus.read, exp_read); end
            if (c < 2) begin
                checks++; if (bus.read !== 2'b01) begin errors++; $display("FAIL en_only0 c%0d: got %b expected 01", c, bus.read); end
            end
            if (c == 2) begin
                checks++; if (bus.read !== 2'b00) begin errors++; $display("FAIL en_drop c%0d: got %b expected 00", c, bus.read); end
            end
            post_edge();
            checks++; if ({bus.out_valid, bus.out_tag, bus.out_data} !== {m_valid, exp_tag, exp_data})
                begin errors++; $display("FAIL en_out c%0d: got %b/%b/%h expected %b/%b/%h", c, bus.out_valid, bus.out_tag, bus.out_data, m_valid, exp_tag, exp_data); end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 8; i++) begin
            push(0, 8'($urandom)); push(1, 8'($urandom));
        end
        for (int c = 0; c < 3; c++) begin
            pre_edge(1'b1, 2'b11);
            checks++; if (bus.read !== exp_read) begin errors++; $display("FAIL rmid_pre_read c%0d: got %b expected %b", c, bus.read, exp_read); end
            post_edge();
        end
        #3;
        rst = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.read !== 2'b00) begin errors++; $display("FAIL rmid_read: got %b expected 00", bus.read); end
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        predict();
        checks++; if (bus.read !== 2'b01) begin errors++; $display("FAIL rmid_first_grant: got %b expected 01", bus.read); end
        post_edge();
        for (int c = 0; c < 20; c++) begin
            pre_edge(1'b1, 2'b11);
            checks++; if (bus.read !== exp_read) begin errors++; $display("FAIL rmid_read c%0d: got %b expected %b", c, bus.read, exp_read); end
            post_edge();
            checks++; if ({bus.out_valid, bus.out_tag, bus.out_data} !== {m_valid, exp_tag, exp_data})
                begin errors++; $display("FAIL rmid_out c%0d: got %b/%b/%h expected %b/%b/%h", c, bus.out_valid, bus.out_tag, bus.out_data, m_valid, exp_tag, exp_data); end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            bit rdy;
            logic [FLUX-1:0] en;
            if (c < 300 && $urandom_range(0, 9) < 4) push(int'($urandom_range(0, FLUX - 1)), 8'($urandom));
            rdy = (c >= 300) || ($urandom_range(0, 3) != 0);
            en  = (c >= 300 || $urandom_range(0, 4) != 0) ? 2'b11 : 2'($urandom);
            pre_edge(rdy, en);
            checks++; if (bus.read !== exp_read) begin errors++; $display("FAIL rand_read c%0d: got %b expected %b", c, bus.read, exp_read); end
            post_edge();
            checks++; if ({bus.out_valid, bus.out_tag, bus.out_data} !== {m_valid, exp_tag, exp_data})
                begin errors++; $display("FAIL rand_out c%0d: got %b/%b/%h expected %b/%b/%h", c, bus.out_valid, bus.out_tag, bus.out_data, m_valid, exp_tag, exp_data); end
        end
        checks++; if (m_q[0].size() != 0 || m_q[1].size() != 0 || wr_ptr[0] != rd_ptr[0] || wr_ptr[1] != rd_ptr[1])
            begin errors++; $display("FAIL rand_drain: got rd %0d/%0d expected %0d/%0d", rd_ptr[0], rd_ptr[1], wr_ptr[0], wr_ptr[1]); end
    endtask

    task automatic test_stats();
        logic [31:0] exp_cnt;
        apply_reset();
        checks++; if (grant_cnt !== '0) begin errors++; $display("FAIL stats_clear: got %h expected 0", grant_cnt); end
        post_edge();
        for (int i = 0; i < 10; i++) push(0, 8'($urandom));
        for (int i = 0; i < 3; i++) push(1, 8'($urandom));
        for (int c = 0; c < 16; c++) begin
            pre_edge(1'b1, 2'b11);
            checks++; if (bus.read !== exp_read) begin errors++; $display("FAIL stats_read c%0d: got %b expected %b", c, bus.read, exp_read); end
            post_edge();
        end
`ifdef FIFO_MS_ARB_STATS_EN
        exp_cnt = {16'd3, 16'd10};
        checks++; if (grant_cnt !== {16'(m_cnt[1]), 16'(m_cnt[0])})
            begin errors++; $display("FAIL stats_model: got %h expected %h", grant_cnt, {16'(m_cnt[1]), 16'(m_cnt[0])}); end
`else
        exp_cnt = 32'd0;
`endif
        checks++; if (grant_cnt !== exp_cnt) begin errors++; $display("FAIL stats_cnt: got %h expected %h", grant_cnt, exp_cnt); end
    endtask

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        bus.out_ready = 1'b0;
        test_reset();
        test_burst_order();
        test_single_flux();
        test_backpressure();
        test_flux_en();
        test_reset_mid();
        test_random();
        test_stats();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
